// File: rtl/vga_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator.
package vga_pkg;

   // Default 640x480 @ 60 Hz timing, in pixel clocks / lines
   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // Width of the pixel coordinate outputs
   localparam int COORD_W = 10;

   // Half-open sync window [lo, hi) along one axis
   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } sync_win_t;

   // Sync pulse starts after visible area and front porch, lasts SYNC counts
   function automatic sync_win_t sync_window(input int visible, input int front, input int sync);
      sync_win_t w;
      w.lo = 32'(visible + front);
      w.hi = 32'(visible + front + sync);
      return w;
   endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping position counter plus visible/sync window flags.
module vga_timing_axis
   import vga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF,
   localparam int TOTAL  = VISIBLE + FRONT + SYNC + BACK,
   localparam int CW     = $clog2(TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          visible,
   output logic          in_sync
);

   localparam sync_win_t       WIN     = sync_window(VISIBLE, FRONT, SYNC);
   localparam logic [CW-1:0]   LAST    = CW'(TOTAL - 1);
   localparam logic [CW-1:0]   VIS_END = CW'(VISIBLE);
   localparam logic [CW-1:0]   SYNC_LO = CW'(WIN.lo);
   localparam logic [CW-1:0]   SYNC_HI = CW'(WIN.hi);

   logic [CW-1:0] r_count;
   logic          w_wrap;

   assign w_wrap  = en && (r_count == LAST);
   assign count   = r_count;
   assign wrap    = w_wrap;
   assign visible = (r_count < VIS_END);
   assign in_sync = (r_count >= SYNC_LO) && (r_count < SYNC_HI);

   // Position counter: advances when enabled, wraps TOTAL-1 -> 0 with no dead cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_wrap ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing: h/v counters, registered sync, visible flag, coordinates and strobes.
module vga_sync_generator
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE   = H_VISIBLE_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_VISIBLE   = V_VISIBLE_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HCW     = $clog2(H_TOTAL);
   localparam int VCW     = $clog2(V_TOTAL);

   // Reject timings that are degenerate or do not fit the coordinate width
   generate
      if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
          V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_param
         $error("vga_sync_generator: every timing parameter must be >= 1");
      end
      if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
         $error("vga_sync_generator: H_TOTAL and V_TOTAL must be <= 1024");
      end
   endgenerate

   logic [HCW-1:0] w_h_count;
   logic [VCW-1:0] w_v_count;
   logic           w_h_wrap;
   logic           w_h_visible;
   logic           w_h_in_sync;
   logic           w_v_visible;
   logic           w_v_in_sync;
   logic           w_unused_v_wrap;
   logic           w_video_on;

   // Horizontal axis runs every pixel clock
   vga_timing_axis #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (1'b1),
      .count   (w_h_count),
      .wrap    (w_h_wrap),
      .visible (w_h_visible),
      .in_sync (w_h_in_sync)
   );

   // Vertical axis steps once per line, on the horizontal wrap
   vga_timing_axis #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (w_h_wrap),
      .count   (w_v_count),
      .wrap    (w_unused_v_wrap),
      .visible (w_v_visible),
      .in_sync (w_v_in_sync)
   );

   assign w_video_on = w_h_visible && w_v_visible;

   logic               r_hsync;
   logic               r_vsync;
   logic               r_video_on;
   logic [COORD_W-1:0] r_pixel_x;
   logic [COORD_W-1:0] r_pixel_y;
   logic               r_line_start;
   logic               r_frame_start;

   // Register the decode of the pre-edge counters; outputs trail the counters by one clock
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_video_on    <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_hsync       <= w_h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync       <= w_v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_video_on    <= w_video_on;
         r_pixel_x     <= w_video_on ? COORD_W'(w_h_count) : '0;
         r_pixel_y     <= w_video_on ? COORD_W'(w_v_count) : '0;
         r_line_start  <= (w_h_count == '0);
         r_frame_start <= (w_h_count == '0) && (w_v_count == '0);
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video_on;
   assign pixel_x     = r_pixel_x;
   assign pixel_y     = r_pixel_y;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: default, small and inverted-polarity instances vs. a position model.
module tb_vga_sync_generator;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // Small timing so whole frames fit in a short run: 25 clocks x 19 lines
   localparam int SHV = 16, SHF = 2, SHS = 3, SHB = 4;
   localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;

   logic       d0_hs, d0_vs, d0_vo, d0_ls, d0_fs;
   logic [9:0] d0_px, d0_py;
   logic       s0_hs, s0_vs, s0_vo, s0_ls, s0_fs;
   logic [9:0] s0_px, s0_py;
   logic       s1_hs, s1_vs, s1_vo, s1_ls, s1_fs;
   logic [9:0] s1_px, s1_py;

   vga_sync_generator u_d0 (
      .clk (clk), .rst (rst), .hsync (d0_hs), .vsync (d0_vs), .video_on (d0_vo),
      .pixel_x (d0_px), .pixel_y (d0_py), .line_start (d0_ls), .frame_start (d0_fs)
   );

   vga_sync_generator #(
      .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
      .SYNC_ACTIVE (1'b0)
   ) u_s0 (
      .clk (clk), .rst (rst), .hsync (s0_hs), .vsync (s0_vs), .video_on (s0_vo),
      .pixel_x (s0_px), .pixel_y (s0_py), .line_start (s0_ls), .frame_start (s0_fs)
   );

   vga_sync_generator #(
      .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
      .SYNC_ACTIVE (1'b1)
   ) u_s1 (
      .clk (clk), .rst (rst), .hsync (s1_hs), .vsync (s1_vs), .video_on (s1_vo),
      .pixel_x (s1_px), .pixel_y (s1_py), .line_start (s1_ls), .frame_start (s1_fs)
   );

   int checks   = 0;
   int failures = 0;
   int k        = 0;   // clock edges since the last reset edge

   // Aggregate observations over the first long run after release
   logic agg_on = 1'b0;
   int s0_vis = 0, s0_pxmax = 0, s0_pymax = 0;
   int s0_vlow = 0, s0_vfirst = 0, s0_vlast = 0, s0_fs2 = 0;
   int d0_hlow = 0, d0_hfirst = 0, d0_hlast = 0, d0_ls2 = 0;
   int s1_hhigh = 0;

   // Expected {hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y}
   // from the raster position implied by the number of edges since reset.
   function automatic logic [24:0] model(input int n,
                                         input int hv, input int hf, input int hsn, input int hb,
                                         input int vv, input int vf, input int vsn, input int vb,
                                         input logic act);
      int   ht, vt, p, h, v;
      logic vo, hs_e, vs_e;
      if (n == 0) return {~act, ~act, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      ht   = hv + hf + hsn + hb;
      vt   = vv + vf + vsn + vb;
      p    = n - 1;
      h    = p % ht;
      v    = (p / ht) % vt;
      vo   = (h < hv) && (v < vv);
      hs_e = (h >= hv + hf) && (h < hv + hf + hsn);
      vs_e = (v >= vv + vf) && (v < vv + vf + vsn);
      return {hs_e ? act : ~act, vs_e ? act : ~act, vo, (h == 0), (h == 0) && (v == 0),
              vo ? 10'(h) : 10'd0, vo ? 10'(v) : 10'd0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("d0_outputs", 32'({d0_hs, d0_vs, d0_vo, d0_ls, d0_fs, d0_px, d0_py}),
          32'(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
      chk("s0_outputs", 32'({s0_hs, s0_vs, s0_vo, s0_ls, s0_fs, s0_px, s0_py}),
          32'(model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0)));
      chk("s1_outputs", 32'({s1_hs, s1_vs, s1_vo, s1_ls, s1_fs, s1_px, s1_py}),
          32'(model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1)));
   endtask

   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      if (r) k = 0;
      else   k++;
      #1;
      check_all();
      if (agg_on) begin
         if (k <= 475) begin
            if (s0_vo) s0_vis++;
            if (int'(s0_px) > s0_pxmax) s0_pxmax = int'(s0_px);
            if (int'(s0_py) > s0_pymax) s0_pymax = int'(s0_py);
            if (!s0_vs) begin
               if (s0_vfirst == 0) s0_vfirst = k;
               s0_vlast = k;
               s0_vlow++;
            end
         end
         if (s0_fs && k > 1 && s0_fs2 == 0) s0_fs2 = k;
         if (k <= 800 && !d0_hs) begin
            if (d0_hfirst == 0) d0_hfirst = k;
            d0_hlast = k;
            d0_hlow++;
         end
         if (d0_ls && k > 1 && d0_ls2 == 0) d0_ls2 = k;
         if (k <= 25 && s1_hs) s1_hhigh++;
      end
   endtask

   initial begin
      int n;
      int guard;

      // Reset held for two edges
      step(1'b1);
      step(1'b1);
      chk("rst_video_on", 32'(s0_vo), 32'd0);
      chk("rst_hsync",    32'(d0_hs), 32'd1);
      chk("rst_hsync_inv", 32'(s1_hs), 32'd0);

      // First edge after release presents position (0,0)
      agg_on = 1'b1;
      step(1'b0);
      chk("first_video_on",    32'(d0_vo), 32'd1);
      chk("first_line_start",  32'(d0_ls), 32'd1);
      chk("first_frame_start", 32'(d0_fs), 32'd1);
      chk("first_pixel_xy",    32'({d0_px, d0_py}), 32'd0);
      chk("first_syncs",       32'({d0_hs, d0_vs}), 32'd3);

      // Over two full default lines and several small frames
      repeat (1699) step(1'b0);
      agg_on = 1'b0;

      chk("d0_hsync_low_count", 32'(d0_hlow),   32'd96);
      chk("d0_hsync_first_low", 32'(d0_hfirst), 32'd657);
      chk("d0_hsync_last_low",  32'(d0_hlast),  32'd752);
      chk("d0_line_period",     32'(d0_ls2),    32'd801);
      chk("s0_visible_edges",   32'(s0_vis),    32'(SHV * SVV));
      chk("s0_pixel_x_max",     32'(s0_pxmax),  32'(SHV - 1));
      chk("s0_pixel_y_max",     32'(s0_pymax),  32'(SVV - 1));
      chk("s0_vsync_low_count", 32'(s0_vlow),   32'(SVS * 25));
      chk("s0_vsync_low_span",  32'(s0_vlast - s0_vfirst + 1), 32'(SVS * 25));
      chk("s0_vsync_first_low", 32'(s0_vfirst), 32'(14 * 25 + 1));
      chk("s0_frame_period",    32'(s0_fs2),    32'd476);
      chk("s1_hsync_high_count", 32'(s1_hhigh), 32'(SHS));

      // Mid-frame reset at small-timing position h=10, v=7
      guard = 0;
      while (((k % 25) != 10 || ((k / 25) % 19) != 7) && guard < 1000) begin
         step(1'b0);
         guard++;
      end
      chk("midframe_reach", 32'(guard < 1000), 32'd1);
      step(1'b1);
      chk("midrst_frame_start", 32'(s0_fs), 32'd0);
      chk("midrst_video_on",    32'(s0_vo), 32'd0);
      step(1'b0);
      chk("after_midrst_frame_start", 32'(s0_fs), 32'd1);
      chk("after_midrst_pixel_xy",    32'({s0_px, s0_py}), 32'd0);

      // Random run lengths interleaved with random-length resets
      for (int r = 0; r < 5; r++) begin
         n = int'($urandom_range(1, 700));
         repeat (n) step(1'b0);
         n = int'($urandom_range(1, 3));
         repeat (n) step(1'b1);
      end
      repeat (30) step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Raster timing stage directly downstream of the clock divider. Its clock input is driven by the divider's divided_clk, used as the pixel clock.
- Generates horizontal and vertical sync, the visible-area flag, current pixel coordinates, and line/frame start strobes for the pixel-colour logic and the VGA DAC pins.
- Default timing is 640x480 @ 60 Hz: 800 clocks per line, 525 lines per frame.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, sync pulse polarity (0 = active-low)

Ports:
- clk  input  1  pixel clock (divided_clk from the clock divider)
- rst  input  1  synchronous, active-high reset
- hsync  output  1  horizontal sync, polarity set by SYNC_ACTIVE
- vsync  output  1  vertical sync, polarity set by SYNC_ACTIVE
- video_on  output  1  high while the pixel is in the visible area
- pixel_x  output  10  column, 0..H_VISIBLE-1; 0 outside the visible area
- pixel_y  output  10  row, 0..V_VISIBLE-1; 0 outside the visible area
- line_start  output  1  one-clock pulse when h_count = 0
- frame_start  output  1  one-clock pulse when h_count = 0 and v_count = 0

Behaviour:
- Internal counters h_count and v_count.
  - H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
  - Counter width is $clog2(TOTAL), 10 bits at default.
- Reset, sampled on the clk edge while rst = 1:
  - h_count = 0, v_count = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
  - video_on = 0, pixel_x = 0, pixel_y = 0, line_start = 0, frame_start = 0.
- Reset asserted mid-frame: the same values apply on the next edge. There is no partial-frame completion.
- Counter advance, every edge with rst = 0:
  - h_count wraps H_TOTAL-1 -> 0; otherwise it increments.
  - v_count increments only on the h wrap. It wraps V_TOTAL-1 -> 0 on the same edge that h wraps from H_TOTAL-1, when v_count = V_TOTAL-1.
- All outputs are registered.
  - Each edge, outputs <= decode(h_count, v_count) of the pre-edge counter values; the counters advance on the same edge.
  - Outputs therefore lag the counters by exactly 1 clock.
  - The first edge after reset release presents decode(0,0): video_on = 1, line_start = 1, frame_start = 1, pixel_x = pixel_y = 0.
- Decode:
  - video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the whole line regardless of h.
  - pixel_x = video_on ? h : 0; pixel_y = video_on ? v : 0. Both are zero-extended to 10 bits.
  - line_start = (h == 0), asserted on every line including blanking lines.
  - frame_start = (h == 0 && v == 0).
- Timing period:
  - Line period is exactly H_TOTAL clocks; frame period is exactly H_TOTAL*V_TOTAL clocks (420000).
  - There is no drift and no dropped cycles at either wrap.
- Elaboration check: each parameter >= 1, and H_TOTAL and V_TOTAL each <= 1024 (the output width). Otherwise $error.

Decomposition:
- Package vga_pkg holds:
  - default 640x480 timing constants;
  - COORD_W = 10;
  - a helper function computing the sync window bounds.
- Sub-module vga_timing_axis is instantiated twice: horizontal with enable tied to 1, vertical with enable = horizontal wrap.
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Outputs: count, wrap, visible, in_sync.
- The top module combines the axis flags, registers the outputs and applies the polarity.

Test Plan:
- Reset then release -> first output edge: video_on = 1, line_start = 1, frame_start = 1, pixel_x = 0, pixel_y = 0, hsync = vsync = 1.
- Count edges after release -> hsync low on edges 657..752 (h = 656..751), high elsewhere; line_start repeats every 800 edges.
- Run one frame -> vsync low for exactly 1600 consecutive edges (lines 490..491); frame_start pulses again after exactly 420000 edges.
- Track pixel_x/pixel_y while video_on is high -> exactly 640x480 = 307200 visible edges per frame; pixel_x reaches 639, pixel_y reaches 479; both are 0 whenever video_on = 0.
- Assert rst for 1 clock at h = 400, v = 300 -> next edge shows the reset values; the following edge shows frame_start = 1 with pixel_x = pixel_y = 0.
- Override SYNC_ACTIVE = 1 -> hsync/vsync invert, high only at h = 656..751 and v = 490..491; other outputs are unchanged.
